muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//   Multi-cycle multiply/divide controller for the CPU execute stage; owns the HI/LO registers.
//   Sequences a shared 1-bit-per-cycle shift-add multiplier / restoring divider with
//   signed/unsigned operand handling, and stalls the pipeline through busy.
//   Sits beside the ALU; operands come from the ID/EX registers, HI/LO feed MFHI/MFLO.
// PARAMETERS
//   WIDTH   32   operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      issue op this cycle (sampled only when busy=0)
//   op           in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//   a            in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
//   b            in   WIDTH  rt operand (multiplier / divisor)
//   flush        in   1      synchronous abort of in-flight op (exception / branch flush)
//   busy         out  1      op in flight; pipeline must stall MFHI/MFLO and new mult/div
//   done         out  1      one-cycle pulse: HI/LO updated at this edge
//   hi, lo       out  WIDTH  architectural HI/LO registers
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, internal regs cleared.
//   States: IDLE -> MUL | DIV -> FIX -> IDLE.
//   IDLE: start && op in {MULT,MULTU} -> MUL; {DIV,DIVU} -> DIV; MTHI -> hi<=a; MTLO -> lo<=a
//     (MTHI/MTLO: single edge, no busy, no done). Unknown op: ignored.
//   On entry: signed ops (MULT/DIV) latch |a|, |b| and result-sign flags; unsigned latch raw.
//   MUL/DIV: exactly WIDTH cycles, one bit per cycle, iteration counter 0..WIDTH-1, then FIX.
//   FIX: apply two's-complement sign correction; hi/lo written at FIX->IDLE edge; done=1
//     for that one cycle. busy=1 in MUL, DIV, FIX; busy=0 in the done cycle.
//   Latency: start edge to done = WIDTH+2 cycles (34 for WIDTH=32).
//   Multiply: {hi,lo} = full 2*WIDTH product; signed product negated if signs of a,b differ.
//   Divide: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
//   Divide by zero (b==0): lo = {WIDTH{1'b1}}, hi = a (raw), no sign correction.
//   Signed min / -1: lo = 1<<(WIDTH-1), hi = 0 (magnitude result, WIDTH-bit wrap).
//   start while busy=1: ignored (including MTHI/MTLO); pipeline guarantees it holds.
//   flush: in any state, next edge -> IDLE, busy=0, no done, hi/lo unchanged;
//     flush && start in same IDLE cycle: start dropped. flush during done cycle: no effect
//     (result already committed).
//   rst_n asserted mid-op: immediate abort, all outputs to reset values.
//   Operands a/b need only be valid in the start cycle.
// CONFIGURATION
//   MULDIV_DIV0_FLAG_EN defined: extra output div0 (1 bit, reset 0) pulses with done
//     when a DIV/DIVU completes with b==0; flushed ops never assert it.
//   Not defined: port absent; div-by-zero results as above, silently.
// TESTING
//   MULT a=FFFFFFFD b=00000005 -> done at cycle 34, hi=FFFFFFFF lo=FFFFFFF1, busy cycles 1..33.
//   MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001.
//   DIV a=FFFFFFF9 b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//   DIVU a=00000007 b=0 -> lo=FFFFFFFF hi=00000007; div0 pulse only with MULDIV_DIV0_FLAG_EN.
//   MULTU started, flush at cycle 10 -> busy=0 at cycle 11, no done, hi/lo keep prior values;
//     MTHI a=12345678 issued while busy -> ignored.
//   MTLO a=CAFEF00D in IDLE -> lo=CAFEF00D next edge, busy/done stay 0; rst_n low mid-DIV -> hi=lo=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide controller that owns the HI/LO registers.
//
// One shared datapath does both jobs: a 1-bit-per-cycle shift-add multiplier and a
// restoring divider. Signed ops are run on magnitudes, and the sign is fixed up in FIX.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start, op    issue request, sampled only while idle
//                op: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b         operands; they need to be valid only in the start cycle
//   flush        synchronous abort of the op in flight; HI/LO are left untouched
//   busy         high while a mult/div is in flight (MUL, DIV and FIX states)
//   done         one-cycle pulse: HI/LO were updated at this edge
//   hi, lo       architectural HI/LO registers
//   div0         present only when MULDIV_DIV0_FLAG_EN is defined; pulses with done
//                when a divide completes with a zero divisor
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIV0_FLAG_EN
    output logic             div0,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    // acc: upper product half / partial remainder
    // q:   multiplier / dividend, shifted into the quotient
    // m:   multiplicand / divisor magnitude
    logic [WIDTH-1:0]  acc, q, m, araw;
    logic              neg_q, neg_r, is_div, bz;

    // Operand magnitudes and sign flags as they are latched at issue.
    logic              sgn_op, sa, sb;
    logic [WIDTH-1:0]  abs_a, abs_b;

    assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
    assign sa     = sgn_op & a[WIDTH-1];
    assign sb     = sgn_op & b[WIDTH-1];
    assign abs_a  = sa ? -a : a;
    assign abs_b  = sb ? -b : b;

    // Multiply step: add the multiplicand when the multiplier LSB is set, then
    // shift {acc,q} right. The carry moves into the top of acc.
    logic [WIDTH:0]    msum;
    assign msum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);

    // Restoring divide step: shift the next dividend bit into the remainder and try
    // a subtract. Bit WIDTH of the difference is the borrow, meaning "keep the old remainder".
    logic [WIDTH:0]    dsh, ddiff;
    assign dsh   = {acc, q[WIDTH-1]};
    assign ddiff = dsh - {1'b0, m};

    // Sign correction used in FIX.
    logic [2*WIDTH-1:0] prod, prod_c;
    logic [WIDTH-1:0]   quo_c, rem_c, dz_hi, res_hi, res_lo;
    assign prod   = {acc, q};
    assign prod_c = neg_q ? -prod : prod;
    assign quo_c  = neg_q ? -q : q;
    assign rem_c  = neg_r ? -acc : acc;
    assign dz_hi  = araw;

    always_comb begin
        res_hi = prod_c[2*WIDTH-1:WIDTH];
        res_lo = prod_c[WIDTH-1:0];
        if (is_div) begin
            if (bz) begin
                res_hi = dz_hi;
                res_lo = '1;
            end else begin
                res_hi = rem_c;
                res_lo = quo_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            araw   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            bz     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULDIV_DIV0_FLAG_EN
            div0   <= 1'b0;
`endif
        end else if (flush) begin
            // Abort: results are discarded and any start in this cycle is dropped.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
            div0  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
                    div0 <= 1'b0;
`endif
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state  <= MUL;
                                busy   <= 1'b1;
                                cnt    <= '0;
                                acc    <= '0;
                                q      <= abs_b;
                                m      <= abs_a;
                                neg_q  <= sa ^ sb;
                                neg_r  <= 1'b0;
                                is_div <= 1'b0;
                                bz     <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                state  <= DIV;
                                busy   <= 1'b1;
                                cnt    <= '0;
                                acc    <= '0;
                                q      <= abs_a;
                                m      <= abs_b;
                                araw   <= a;
                                is_div <= 1'b1;
                                bz     <= (b == '0);
                                neg_q  <= sa ^ sb;
                                neg_r  <= sa;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc <= msum[WIDTH:1];
                    q   <= {msum[0], q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) state <= FIX;
                end
                DIV: begin
                    if (!ddiff[WIDTH]) begin
                        acc <= ddiff[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= dsh[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef MULDIV_DIV0_FLAG_EN
                    div0  <= is_div & bz;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl (WIDTH=32).
// Directed cases come first, then flush, reset and randomized ops. Every result is
// compared against a plain-arithmetic model of HI/LO kept here in the bench.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] a = '0, b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MULDIV_DIV0_FLAG_EN
    logic        div0;
`endif

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done),
`ifdef MULDIV_DIV0_FLAG_EN
        .div0(div0),
`endif
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int npass = 0, nchk = 0;
    logic [31:0] ref_hi = '0, ref_lo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: the architectural effect of one op on HI/LO.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl, output logic d0);
        logic signed [63:0] sp;
        logic [63:0]        up;
        rh = ref_hi; rl = ref_lo; d0 = 1'b0;
        case (o)
            3'd0: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                rh = sp[63:32]; rl = sp[31:0];
            end
            3'd1: begin
                up = {32'b0, x} * {32'b0, y};
                rh = up[63:32]; rl = up[31:0];
            end
            3'd2, 3'd3: begin
                if (y == 0) begin
                    rl = 32'hFFFFFFFF; rh = x; d0 = 1'b1;
                end else if (o == 3'd2 && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                    rl = 32'h80000000; rh = 32'h0;
                end else if (o == 3'd2) begin
                    rl = $signed(x) / $signed(y); rh = $signed(x) % $signed(y);
                end else begin
                    rl = x / y; rh = x % y;
                end
            end
            3'd4: rh = x;
            3'd5: rl = x;
            default: ;
        endcase
    endtask

    // Issue one op at a negedge, then check latency, busy, the done pulse and the results.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] eh, el;
        logic        ed0, busy_ok;
        int          cyc;
        model(o, x, y, eh, el, ed0);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        if (o <= 3'd3) begin
            cyc = 1; busy_ok = 1'b1;
            while (done !== 1'b1 && cyc < 50) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                @(negedge clk);
                cyc++;
            end
            chk({tag, ".lat"}, 64'(cyc), 64'd34);
            chk({tag, ".busy_run"}, 64'(busy_ok), 64'd1);
            chk({tag, ".busy_done"}, 64'(busy), 64'd0);
`ifdef MULDIV_DIV0_FLAG_EN
            chk({tag, ".div0"}, 64'(div0), 64'(ed0 & (o >= 3'd2)));
`endif
        end else begin
            chk({tag, ".busy"}, 64'(busy), 64'd0);
            chk({tag, ".done"}, 64'(done), 64'd0);
        end
        chk({tag, ".hi"}, 64'(hi), 64'(eh));
        chk({tag, ".lo"}, 64'(lo), 64'(el));
        ref_hi = eh; ref_lo = el;
    endtask

    initial begin
        logic saw_done;
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mult", 3'd0, 32'hFFFFFFFD, 32'h00000005);
        chk("mult.hi_const", 64'(hi), 64'h0FFFFFFFF);
        chk("mult.lo_const", 64'(lo), 64'h0FFFFFFF1);
        do_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu.hi_const", 64'(hi), 64'h0FFFFFFFE);
        do_op("div", 3'd2, 32'hFFFFFFF9, 32'h00000002);
        chk("div.lo_const", 64'(lo), 64'h0FFFFFFFD);
        do_op("divmin", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        do_op("divu0", 3'd3, 32'h00000007, 32'h0);
        do_op("divs0", 3'd2, 32'hFFFFFFF0, 32'h0);
        do_op("mtlo", 3'd5, 32'hCAFEF00D, 32'h0);
        chk("mtlo.lo_const", 64'(lo), 64'h0CAFEF00D);
        do_op("mthi", 3'd4, 32'h0BADBEEF, 32'h0);
        do_op("nop", 3'd7, 32'h11111111, 32'h22222222);

        // Flush at cycle 10 of a MULTU; an MTHI issued while busy must be ignored.
        @(negedge clk);
        op = 3'd1; a = 32'h12345; b = 32'h6789; start = 1'b1;
        @(negedge clk);
        for (int c = 1; c < 11; c++) begin
            start = (c == 5);
            op = 3'd4; a = 32'h12345678;
            flush = (c == 10);
            @(negedge clk);
        end
        start = 1'b0; flush = 1'b0;
        chk("flush.busy", 64'(busy), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("flush.nodone", 64'(saw_done), 64'd0);
        chk("flush.hi", 64'(hi), 64'(ref_hi));
        chk("flush.lo", 64'(lo), 64'(ref_lo));

        // A flush together with start in an idle cycle drops the start.
        op = 3'd0; a = 32'h7; b = 32'h9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flstart.busy", 64'(busy), 64'd0);
        repeat (36) @(negedge clk);
        chk("flstart.hi", 64'(hi), 64'(ref_hi));
        chk("flstart.lo", 64'(lo), 64'(ref_lo));

        // Randomized ops, with the corner operands mixed in.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom; ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'h0;
                1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
                2: ry = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), ro, rx, ry);
        end

        // Reset asserted in the middle of a DIV.
        @(negedge clk);
        op = 3'd2; a = 32'h1000; b = 32'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid.busy", 64'(busy), 64'd0);
        chk("rstmid.done", 64'(done), 64'd0);
        chk("rstmid.hi", 64'(hi), 64'd0);
        chk("rstmid.lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_hi = '0; ref_lo = '0;
        do_op("post_rst", 3'd3, 32'd100, 32'd7);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
